// File: rtl/branch_predict_resolve.sv
// Branch unit: BHT-based prediction at IF, compare-and-resolve at EX with
// registered outcome, BHT training and saturating performance counters.
module branch_predict_resolve #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_BITS    = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      if_pc,
    output logic                 predict_taken,
    input  logic                 ex_valid,
    input  logic [2:0]           ex_signal,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic [XLEN-1:0]      ex_data1,
    input  logic [XLEN-1:0]      ex_data2,
    input  logic                 ex_pred_taken,
    output logic                 resolve_valid,
    output logic                 branch_taken,
    output logic                 mispredict,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int INDEX_BITS = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0]  CTR_MAX = {CTR_BITS{1'b1}};
    // Weakly-not-taken: all ones below the MSB; collapses to 0 for 1-bit counters.
    localparam logic [CTR_BITS-1:0]  CTR_WNT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_RSVD = 3'd7
    } branch_op_e;

    function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
        logic [CTR_BITS-1:0] r;
        if (c == CTR_MAX) begin
            r = c;
        end else begin
            r = c + CTR_BITS'(1);
        end
        return r;
    endfunction

    function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
        logic [CTR_BITS-1:0] r;
        if (c == {CTR_BITS{1'b0}}) begin
            r = c;
        end else begin
            r = c - CTR_BITS'(1);
        end
        return r;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
        logic [CNT_WIDTH-1:0] r;
        if (c == CNT_MAX) begin
            r = c;
        end else begin
            r = c + CNT_WIDTH'(1);
        end
        return r;
    endfunction

    logic [CTR_BITS-1:0]   bht_r [BHT_ENTRIES];
    logic                  resolve_valid_r;
    logic                  branch_taken_r;
    logic                  mispredict_r;
    logic [CNT_WIDTH-1:0]  branch_count_r;
    logic [CNT_WIDTH-1:0]  miss_count_r;

    logic [INDEX_BITS-1:0] if_idx_s;
    logic [INDEX_BITS-1:0] ex_idx_s;
    branch_op_e            op_s;
    logic                  eq_s;
    logic                  lt_s;
    logic                  ltu_s;
    logic                  taken_s;
    logic                  is_branch_s;
    logic                  resolve_s;
    logic                  miss_s;
    logic                  predict_s;
    logic [CTR_BITS-1:0]   ctr_next_s;
    logic                  unused_pc_bits_s;

    // PC bits [1:0] are always zero for aligned instructions, so indexing skips them.
    assign if_idx_s = if_pc[INDEX_BITS+1:2];
    assign ex_idx_s = ex_pc[INDEX_BITS+1:2];
    assign unused_pc_bits_s = ^{if_pc[1:0], if_pc[XLEN-1:INDEX_BITS+2],
                                ex_pc[1:0], ex_pc[XLEN-1:INDEX_BITS+2]};

    assign op_s  = branch_op_e'(ex_signal);
    assign eq_s  = (ex_data1 == ex_data2);
    assign lt_s  = ($signed(ex_data1) < $signed(ex_data2));
    assign ltu_s = (ex_data1 < ex_data2);

    // Actual branch outcome for the operation in EX.
    always_comb begin
        taken_s = 1'b0;
        case (op_s)
            BR_BEQ:  taken_s = eq_s;
            BR_BNE:  taken_s = !eq_s;
            BR_BLT:  taken_s = lt_s;
            BR_BGE:  taken_s = !lt_s;
            BR_BLTU: taken_s = ltu_s;
            BR_BGEU: taken_s = !ltu_s;
            default: taken_s = 1'b0;
        endcase
    end

    // Resolve qualification: only valid, real branch encodings train and count.
    always_comb begin
        is_branch_s = 1'b0;
        case (op_s)
            BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: is_branch_s = 1'b1;
            default:                                          is_branch_s = 1'b0;
        endcase
    end

    assign resolve_s = ex_valid && is_branch_s;
    assign miss_s    = taken_s ^ ex_pred_taken;

    // Trained counter value for the EX index.
    always_comb begin
        ctr_next_s = bht_r[ex_idx_s];
        if (taken_s) begin
            ctr_next_s = ctr_inc(bht_r[ex_idx_s]);
        end else begin
            ctr_next_s = ctr_dec(bht_r[ex_idx_s]);
        end
    end

    // Prediction reads the stored counter, so a same-cycle update is not yet visible.
    always_comb begin
        predict_s = 1'b0;
        if (reset) begin
            predict_s = 1'b0;
        end else begin
            predict_s = bht_r[if_idx_s][CTR_BITS-1];
        end
    end

    assign predict_taken = predict_s;

    // BHT storage: reset to weakly-not-taken, trained on each resolve.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= CTR_WNT;
            end
        end else if (resolve_s) begin
            bht_r[ex_idx_s] <= ctr_next_s;
        end
    end

    // Resolution outputs: one-cycle pulses following each resolve.
    always_ff @(posedge clk) begin
        if (reset) begin
            resolve_valid_r <= 1'b0;
            branch_taken_r  <= 1'b0;
            mispredict_r    <= 1'b0;
        end else begin
            resolve_valid_r <= resolve_s;
            branch_taken_r  <= resolve_s && taken_s;
            mispredict_r    <= resolve_s && miss_s;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_r <= {CNT_WIDTH{1'b0}};
            miss_count_r   <= {CNT_WIDTH{1'b0}};
        end else if (resolve_s) begin
            branch_count_r <= cnt_inc(branch_count_r);
            if (miss_s) begin
                miss_count_r <= cnt_inc(miss_count_r);
            end
        end
    end

    assign resolve_valid = resolve_valid_r;
    assign branch_taken  = branch_taken_r;
    assign mispredict    = mispredict_r;
    assign branch_count  = branch_count_r;
    assign miss_count    = miss_count_r;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve with an outcome-level reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_branch_predict_resolve;

    localparam int ENT = 16;
    localparam int CW  = 4;
    localparam int CNT_SAT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   if_pc;
    logic          predict_taken;
    logic          ex_valid;
    logic [2:0]    ex_signal;
    logic [31:0]   ex_pc;
    logic [31:0]   ex_data1;
    logic [31:0]   ex_data2;
    logic          ex_pred_taken;
    logic          resolve_valid;
    logic          branch_taken;
    logic          mispredict;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] miss_count;

    int tests = 0;
    int fails = 0;

    int bht_m [ENT];
    int bc_m;
    int mc_m;
    bit rv_m;
    bit bt_m;
    bit mp_m;
    bit model_ready = 1'b0;

    always #5 clk = ~clk;

    branch_predict_resolve #(
        .XLEN(32), .BHT_ENTRIES(ENT), .CTR_BITS(2), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .predict_taken(predict_taken),
        .ex_valid(ex_valid), .ex_signal(ex_signal), .ex_pc(ex_pc),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_pred_taken(ex_pred_taken),
        .resolve_valid(resolve_valid), .branch_taken(branch_taken),
        .mispredict(mispredict), .branch_count(branch_count), .miss_count(miss_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outcome straight from the ISA definition, signed values via 64-bit arithmetic.
    function automatic bit br_taken(input int sig, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = a[31] ? (longint'(a) - 64'sd4294967296) : longint'(a);
        sb = b[31] ? (longint'(b) - 64'sd4294967296) : longint'(b);
        case (sig)
            1: return a == b;
            2: return a != b;
            3: return sa < sb;
            4: return sa >= sb;
            5: return a < b;
            6: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_pred();
        return !reset && (bht_m[(if_pc / 4) % ENT] >= 2);
    endfunction

    task automatic model_step();
        bit t;
        int idx;
        if (reset) begin
            for (int i = 0; i < ENT; i++) bht_m[i] = 1;
            rv_m = 0; bt_m = 0; mp_m = 0; bc_m = 0; mc_m = 0;
            model_ready = 1'b1;
        end else if (ex_valid && ex_signal >= 3'd1 && ex_signal <= 3'd6) begin
            t    = br_taken(int'(ex_signal), ex_data1, ex_data2);
            idx  = (ex_pc / 4) % ENT;
            rv_m = 1; bt_m = t; mp_m = (t != ex_pred_taken);
            if (t) bht_m[idx] = (bht_m[idx] < 3) ? bht_m[idx] + 1 : 3;
            else   bht_m[idx] = (bht_m[idx] > 0) ? bht_m[idx] - 1 : 0;
            if (bc_m < CNT_SAT) bc_m++;
            if (mp_m && mc_m < CNT_SAT) mc_m++;
        end else begin
            rv_m = 0; bt_m = 0; mp_m = 0;
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ready) begin
            chk("cmp_predict", 32'(predict_taken), 32'(m_pred()));
            chk("cmp_resolve_valid", 32'(resolve_valid), 32'(rv_m));
            chk("cmp_branch_taken", 32'(branch_taken), 32'(bt_m));
            chk("cmp_mispredict", 32'(mispredict), 32'(mp_m));
            chk("cmp_branch_count", 32'(branch_count), 32'(bc_m));
            chk("cmp_miss_count", 32'(miss_count), 32'(mc_m));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic set_ex(input logic v, input logic [2:0] sig, input logic [31:0] pc,
                          input logic [31:0] d1, input logic [31:0] d2, input logic pt);
        ex_valid = v; ex_signal = sig; ex_pc = pc;
        ex_data1 = d1; ex_data2 = d2; ex_pred_taken = pt;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0;
        ex_signal = 3'd0;
    endtask

    // One EX-stage cycle; returns at the negedge where the registered result is visible.
    task automatic resolve(input logic v, input logic [2:0] sig, input logic [31:0] pc,
                           input logic [31:0] d1, input logic [31:0] d2, input logic pt);
        #1;
        set_ex(v, sig, pc, d1, d2, pt);
        tick();
        idle_ex();
        @(negedge clk);
    endtask

    task automatic peek_pred(input string name, input logic [31:0] pc, input logic exp);
        #1;
        if_pc = pc;
        #1;
        chk(name, 32'(predict_taken), 32'(exp));
    endtask

    task automatic sweep_pred_zero(input string name);
        for (int i = 0; i < ENT; i++) begin
            #1;
            if_pc = 32'(i * 4);
            @(negedge clk);
            chk(name, 32'(predict_taken), 32'd0);
        end
    endtask

    task automatic chk_out(input string tag, input logic rv, input logic bt, input logic mp,
                           input int bc, input int mc);
        chk({tag, "_rv"}, 32'(resolve_valid), 32'(rv));
        chk({tag, "_bt"}, 32'(branch_taken), 32'(bt));
        chk({tag, "_mp"}, 32'(mispredict), 32'(mp));
        chk({tag, "_bc"}, 32'(branch_count), 32'(bc));
        chk({tag, "_mc"}, 32'(miss_count), 32'(mc));
    endtask

    initial begin
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  sig;
        bit          pt;

        reset = 1'b1;
        if_pc = 32'd0;
        set_ex(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("reset_pred_forced", 32'(predict_taken), 32'd0);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 0, 0);
        tick();
        reset = 1'b0;
        sweep_pred_zero("reset_sweep_pred");
        chk_out("after_reset", 1'b0, 1'b0, 1'b0, 0, 0);

        // BEQ equal operands, predicted not-taken: mispredict, counter 1 -> 2.
        resolve(1'b1, 3'd1, 32'h10, 32'd5, 32'd5, 1'b0);
        chk_out("beq", 1'b1, 1'b1, 1'b1, 1, 1);
        peek_pred("beq_trained_pred", 32'h10, 1'b1);

        // Signed versus unsigned compare of -1 and 1.
        resolve(1'b1, 3'd3, 32'h84, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk_out("blt_neg", 1'b1, 1'b1, 1'b1, 2, 2);
        resolve(1'b1, 3'd5, 32'h88, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk_out("bltu_big", 1'b1, 1'b0, 1'b0, 3, 2);
        resolve(1'b1, 3'd6, 32'h8C, 32'hFFFF_FFFF, 32'd1, 1'b1);
        chk_out("bgeu_big", 1'b1, 1'b1, 1'b0, 4, 2);

        // Counter saturation at 0x20.
        for (int i = 0; i < 4; i++) begin
            resolve(1'b1, 3'd2, 32'h20, 32'd1, 32'd2, 1'b1);
            chk("sat_bne_taken", 32'(branch_taken), 32'd1);
        end
        peek_pred("sat_pred_high", 32'h20, 1'b1);
        resolve(1'b1, 3'd2, 32'h20, 32'd7, 32'd7, 1'b1);
        peek_pred("sat_one_nt_pred", 32'h20, 1'b1);
        resolve(1'b1, 3'd2, 32'h20, 32'd7, 32'd7, 1'b1);
        peek_pred("sat_two_nt_pred", 32'h20, 1'b0);
        chk_out("sat_counts", 1'b1, 1'b0, 1'b1, 10, 4);

        // Aliasing 0x40 onto index 0, read-before-write with IF_PC=0x00.
        #1;
        if_pc = 32'h0;
        set_ex(1'b1, 3'd1, 32'h40, 32'd3, 32'd3, 1'b0);
        #1;
        chk("rbw_same_cycle_pred", 32'(predict_taken), 32'd0);
        tick();
        idle_ex();
        @(negedge clk);
        chk("rbw_next_cycle_pred", 32'(predict_taken), 32'd1);
        chk_out("alias", 1'b1, 1'b1, 1'b1, 11, 5);

        // Reserved encoding and invalid EX are no-ops.
        resolve(1'b1, 3'd7, 32'h40, 32'd3, 32'd4, 1'b0);
        chk_out("sig7_noop", 1'b0, 1'b0, 1'b0, 11, 5);
        peek_pred("sig7_bht_kept", 32'h0, 1'b1);
        resolve(1'b0, 3'd2, 32'h0, 32'd3, 32'd4, 1'b0);
        chk_out("invalid_noop", 1'b0, 1'b0, 1'b0, 11, 5);

        resolve(1'b1, 3'd4, 32'h30, 32'd9, 32'd9, 1'b1);
        chk_out("bge_equal", 1'b1, 1'b1, 1'b0, 12, 5);
        resolve(1'b1, 3'd3, 32'h34, 32'd5, 32'hFFFF_FFFD, 1'b0);
        chk_out("blt_pos_vs_neg", 1'b1, 1'b0, 1'b0, 13, 5);

        // Twenty mispredicted resolves: 4-bit statistics must stop at 15.
        for (int i = 0; i < 20; i++) begin
            sig = 3'(1 + (i % 6));
            d1  = $urandom;
            d2  = (i % 3 == 0) ? d1 : $urandom;
            if (i % 4 == 1) d2 = ~d1;
            pt  = !br_taken(int'(sig), d1, d2);
            resolve(1'b1, sig, 32'(i * 4), d1, d2, pt);
            chk("sat_loop_mispredict", 32'(mispredict), 32'd1);
        end
        chk_out("stat_saturate", 1'b1, branch_taken, 1'b1, 15, 15);

        // Reset wins over a concurrent resolve.
        #1;
        reset = 1'b1;
        set_ex(1'b1, 3'd2, 32'h24, 32'd1, 32'd2, 1'b0);
        tick();
        reset = 1'b0;
        idle_ex();
        @(negedge clk);
        chk_out("reset_with_resolve", 1'b0, 1'b0, 1'b0, 0, 0);
        sweep_pred_zero("post_reset_sweep_pred");
        resolve(1'b1, 3'd2, 32'h24, 32'd1, 32'd2, 1'b0);
        chk_out("post_reset_resolve", 1'b1, 1'b1, 1'b1, 1, 1);
        peek_pred("post_reset_weak_nt", 32'h24, 1'b1);

        tick();
        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Parametrised branch unit for the RV32IM pipeline: predicts conditional branches at IF and resolves them at EX.
- Prediction uses a direct-mapped branch history table (BHT) of saturating counters. Resolution performs the EQ/LT/LTU compare internally.
- Resolution outputs (taken, mispredict) are registered. The BHT updates on resolution.
- Saturating statistics counters track resolved branches and mispredicts for performance debug.

Parameters:
- XLEN, 32: operand and PC width.
- BHT_ENTRIES, 16: number of BHT entries; power of two, minimum 2.
- CTR_BITS, 2: width of each saturating counter; minimum 1.
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- IF_PC  input  XLEN  PC of the instruction being fetched.
- PREDICT_TAKEN  output  1  combinational prediction for IF_PC.
- EX_VALID  input  1  EX stage holds a valid instruction.
- EX_SIGNAL  input  3  branch type: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 reserved.
- EX_PC  input  XLEN  PC of the branch in EX.
- EX_DATA1  input  XLEN  rs1 value.
- EX_DATA2  input  XLEN  rs2 value.
- EX_PRED_TAKEN  input  1  prediction made at IF for this instruction, carried down the pipe.
- RESOLVE_VALID  output  1  registered; a branch resolved last cycle.
- BRANCH_TAKEN  output  1  registered actual outcome.
- MISPREDICT  output  1  registered; actual outcome differs from EX_PRED_TAKEN.
- BRANCH_COUNT  output  CNT_WIDTH  number of resolved branches.
- MISS_COUNT  output  CNT_WIDTH  number of mispredicts.

Behaviour:
- Index
  - INDEX_BITS = log2(BHT_ENTRIES).
  - index = PC[INDEX_BITS+1:2]; PC bits [1:0] are ignored.
  - Aliasing is permitted; there are no tags.
- Reset
  - Every BHT counter is set to weakly-not-taken, 2^(CTR_BITS-1)-1; for CTR_BITS=1 this is 0.
  - RESOLVE_VALID, BRANCH_TAKEN, MISPREDICT, BRANCH_COUNT and MISS_COUNT are cleared to 0.
  - While RESET is high, PREDICT_TAKEN is forced to 0.
  - Reset takes priority over a concurrent resolve; that branch is discarded.
- Prediction
  - PREDICT_TAKEN is the MSB of the counter at the IF_PC index. Purely combinational.
- Compare
  - EQ = (EX_DATA1 == EX_DATA2).
  - LT is the two's-complement signed less-than.
  - LTU is the unsigned less-than.
  - taken per EX_SIGNAL: BEQ = EQ, BNE = !EQ, BLT = LT, BGE = !LT, BLTU = LTU, BGEU = !LTU.
- Resolve
  - A resolve occurs when EX_VALID=1 and EX_SIGNAL is in 1..6.
  - On the following rising edge:
    - RESOLVE_VALID=1.
    - BRANCH_TAKEN=taken.
    - MISPREDICT = taken XOR EX_PRED_TAKEN.
  - Latency is exactly 1 cycle.
  - Each output is held for one cycle only. The next edge without a resolve sets RESOLVE_VALID, BRANCH_TAKEN and MISPREDICT to 0.
  - EX_SIGNAL 0 or 7, or EX_VALID=0, is a no-op: no BHT or statistics update, and resolution outputs are 0 the next cycle.
- BHT update
  - On the same edge as the resolve, the counter at the EX_PC index is updated.
  - If taken, increment, saturating at 2^CTR_BITS-1.
  - If not taken, decrement, saturating at 0.
  - Back-to-back resolves are accepted every cycle.
- Simultaneous read/write
  - When IF_PC and EX_PC map to the same index in the same cycle, PREDICT_TAKEN reflects the pre-update value (read-before-write).
  - The updated value is visible from the next cycle.
- Statistics
  - BRANCH_COUNT increments by 1 per resolve.
  - MISS_COUNT increments by 1 per mispredict.
  - Both update on the resolve edge, i.e. the same edge that raises RESOLVE_VALID.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: a resolve pending in the same cycle as RESET has no effect on any state.

Test Plan:
- Reset, then sweep IF_PC over all indices -> PREDICT_TAKEN=0 everywhere; all outputs and counters 0.
- BEQ at EX_PC=0x10, DATA1=DATA2=5, EX_PRED_TAKEN=0:
  - next cycle: RESOLVE_VALID=1, BRANCH_TAKEN=1, MISPREDICT=1, BRANCH_COUNT=1, MISS_COUNT=1;
  - afterwards, IF_PC=0x10 gives PREDICT_TAKEN=1 (counter 1->2).
- Signed vs unsigned compare:
  - BLT with DATA1=0xFFFFFFFF, DATA2=1 -> taken;
  - BLTU with the same operands -> not taken;
  - BGEU with the same operands -> taken.
- Saturation:
  - four consecutive taken BNEs at 0x20 -> counter stays at 3;
  - then one not-taken -> PREDICT_TAKEN remains 1;
  - then a second not-taken -> PREDICT_TAKEN=0.
- Aliasing and read-before-write, BHT_ENTRIES=16:
  - a taken resolve at EX_PC=0x40 while IF_PC=0x00 in the same cycle -> PREDICT_TAKEN=0 that cycle and 1 the next;
  - EX_SIGNAL=7 with EX_VALID=1 -> no update.
- CNT_WIDTH=4:
  - 20 mispredicted resolves -> BRANCH_COUNT=MISS_COUNT=15, no wrap;
  - assert RESET together with a resolve -> all outputs 0 next cycle and BHT at reset values.
